// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory server and its storage array.
package imem_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } imem_state_t;

    // Returned for every fetch that does not hit a loaded word; the core halts on it.
    localparam logic [31:0] BREAK_INSTR = 32'h0000_000D;

    // Wide enough for the largest legal RESET_HOLD (15).
    localparam int HOLD_CNT_W = 4;

endpackage

// File: rtl/imem_array.sv
// Instruction store: one synchronous write port, one asynchronous read port, no reset.
module imem_array #(
    parameter int ADDR_SIZE  = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_SIZE-1:0]  waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_SIZE-1:0]  raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_SIZE;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_server.sv
// Loads a program from a valid/ready stream, holds the core in reset, then serves
// zero-latency instruction fetches and counts run cycles until the core halts.
module imem_server
    import imem_pkg::*;
#(
    parameter int ADDR_SIZE  = 6,
    parameter int DATA_WIDTH = 32,
    parameter int RESET_HOLD = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic [31:0]           raddr,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  core_reset,
    input  logic                  halted,
    output logic                  done,
    output logic [31:0]           cycle_count,
    output logic [ADDR_SIZE:0]    loaded_words
);

    localparam int DEPTH = 2 ** ADDR_SIZE;
    localparam int LW_W  = ADDR_SIZE + 1;

    imem_state_t           state_q, state_d;
    logic                  load_ready_q;
    logic [LW_W-1:0]       loaded_words_q, loaded_words_d;
    logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [31:0]           cycle_count_q, cycle_count_d;

    logic                  load_fire;
    logic                  load_final;
    logic                  in_range;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // load_ready_q is only ever high in LOAD, so it alone qualifies the handshake.
    assign load_fire  = load_valid & load_ready_q;
    assign load_final = load_last | (loaded_words_q == LW_W'(DEPTH - 1));
    assign in_range   = (raddr < 32'(loaded_words_q));

    always_comb begin
        state_d        = state_q;
        loaded_words_d = loaded_words_q;
        hold_cnt_d     = hold_cnt_q;
        cycle_count_d  = cycle_count_q;

        case (state_q)
            LOAD: begin
                if (load_fire) begin
                    loaded_words_d = loaded_words_q + 1'b1;
                    if (load_final) begin
                        state_d    = HOLD;
                        hold_cnt_d = HOLD_CNT_W'(RESET_HOLD - 1);
                    end
                end
            end
            HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            RUN: begin
                // The cycle that samples halted is still counted.
                if (cycle_count_q != 32'hFFFF_FFFF) begin
                    cycle_count_d = cycle_count_q + 32'd1;
                end
                if (halted) begin
                    state_d = DONE;
                end
            end
            DONE: begin
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= LOAD;
            load_ready_q   <= 1'b0;
            loaded_words_q <= '0;
            hold_cnt_q     <= '0;
            cycle_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            load_ready_q   <= (state_d == LOAD);
            loaded_words_q <= loaded_words_d;
            hold_cnt_q     <= hold_cnt_d;
            cycle_count_q  <= cycle_count_d;
        end
    end

    imem_array #(
        .ADDR_SIZE  (ADDR_SIZE),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk_i   (clock),
        .we_i    (load_fire),
        .waddr_i (loaded_words_q[ADDR_SIZE-1:0]),
        .wdata_i (load_data),
        .raddr_i (raddr[ADDR_SIZE-1:0]),
        .rdata_o (mem_rdata)
    );

    assign instr        = ((state_q == RUN) && in_range) ? mem_rdata : DATA_WIDTH'(BREAK_INSTR);
    assign core_reset   = (state_q != RUN);
    assign done         = (state_q == DONE);
    assign load_ready   = load_ready_q;
    assign cycle_count  = cycle_count_q;
    assign loaded_words = loaded_words_q;

endmodule

// File: tb/tb_imem_server.sv
// Directed bench for imem_server: program load, reset hold, fetch bounds, halt and async reset.
module tb_imem_server;
    import imem_pkg::*;

    localparam int ADDR_SIZE  = 6;
    localparam int DATA_WIDTH = 32;
    localparam int RESET_HOLD = 4;

    logic                  clock      = 1'b0;
    logic                  reset      = 1'b0;
    logic                  load_valid = 1'b0;
    logic                  load_last  = 1'b0;
    logic                  halted     = 1'b0;
    logic [DATA_WIDTH-1:0] load_data  = '0;
    logic [31:0]           raddr      = '0;
    logic                  load_ready;
    logic                  core_reset;
    logic                  done;
    logic [DATA_WIDTH-1:0] instr;
    logic [31:0]           cycle_count;
    logic [ADDR_SIZE:0]    loaded_words;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] raddr;
        logic [31:0] exp_instr;
    } fetch_vec_t;

    fetch_vec_t tbl[$];

    imem_server #(
        .ADDR_SIZE  (ADDR_SIZE),
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_HOLD (RESET_HOLD)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .load_last    (load_last),
        .raddr        (raddr),
        .instr        (instr),
        .core_reset   (core_reset),
        .halted       (halted),
        .done         (done),
        .cycle_count  (cycle_count),
        .loaded_words (loaded_words)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Asserts reset across one rising edge and releases it mid-cycle; returns one edge after release.
    task automatic apply_reset();
        reset      = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        halted     = 1'b0;
        @(posedge clock);
        #3;
        reset = 1'b1;
        tick();
    endtask

    task automatic load_word(input string name, input logic [31:0] data, input logic last);
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        check({name, "_ready_before_accept"}, 32'(load_ready), 32'd1);
        tick();
    endtask

    // Called right after the final accepting edge: core_reset holds for RESET_HOLD cycles.
    task automatic hold_to_run(input string name);
        for (int i = 0; i < RESET_HOLD; i++) begin
            check($sformatf("%s_hold_core_reset[%0d]", name, i), 32'(core_reset), 32'd1);
            check($sformatf("%s_hold_ready[%0d]", name, i), 32'(load_ready), 32'd0);
            tick();
        end
        check({name, "_run_core_reset"}, 32'(core_reset), 32'd0);
    endtask

    task automatic run_table(input string name);
        foreach (tbl[i]) begin
            raddr = tbl[i].raddr;
            #1;
            check($sformatf("%s_fetch[%0d]", name, i), instr, tbl[i].exp_instr);
        end
    endtask

    initial begin
        // Reset values while reset is held low
        #2;
        check("rst_load_ready", 32'(load_ready), 32'd0);
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cycle_count", cycle_count, 32'd0);
        check("rst_loaded_words", 32'(loaded_words), 32'd0);
        check("rst_instr", instr, 32'h0000000D);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("rel_ready_before_edge", 32'(load_ready), 32'd0);
        tick();
        check("rel_ready_after_edge", 32'(load_ready), 32'd1);

        // Scenario 1: three-word program with load_valid held high
        load_word("s1w0", 32'h20010005, 1'b0);
        check("s1_lw_after_w0", 32'(loaded_words), 32'd1);
        load_word("s1w1", 32'h20020007, 1'b0);
        load_word("s1w2", 32'h0000000D, 1'b1);
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("s1_loaded_words", 32'(loaded_words), 32'd3);
        check("s1_ready_drop", 32'(load_ready), 32'd0);
        hold_to_run("s1");
        check("s1_cycle_start", cycle_count, 32'd0);

        tbl = '{};
        tbl.push_back('{32'd0,          32'h20010005});
        tbl.push_back('{32'd1,          32'h20020007});
        tbl.push_back('{32'd2,          32'h0000000D});
        tbl.push_back('{32'd3,          32'h0000000D});
        tbl.push_back('{32'd64,         32'h0000000D});
        tbl.push_back('{32'h80000001,   32'h0000000D});
        run_table("s1");

        raddr = 32'd1;
        for (int i = 0; i < 10; i++) tick();
        check("s1_cycle_10", cycle_count, 32'd10);
        check("s1_done_before_halt", 32'(done), 32'd0);
        halted = 1'b1;
        tick();
        check("s1_done", 32'(done), 32'd1);
        check("s1_cycle_11", cycle_count, 32'd11);
        check("s1_done_core_reset", 32'(core_reset), 32'd1);
        check("s1_done_instr", instr, 32'h0000000D);
        halted = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("s1_cycle_frozen", cycle_count, 32'd11);
        check("s1_done_sticky", 32'(done), 32'd1);
        check("s1_lw_frozen", 32'(loaded_words), 32'd3);

        // Scenario 2: load_valid toggling, junk data and load_last on idle cycles
        apply_reset();
        check("s2_lw_reset", 32'(loaded_words), 32'd0);
        check("s2_done_reset", 32'(done), 32'd0);
        load_valid = 1'b1; load_data = 32'h11111111; load_last = 1'b0;
        tick();
        check("s2_lw_a", 32'(loaded_words), 32'd1);
        load_valid = 1'b0; load_data = 32'hBAD0BAD0; load_last = 1'b1;
        tick();
        check("s2_lw_idle0", 32'(loaded_words), 32'd1);
        check("s2_ready_idle0", 32'(load_ready), 32'd1);
        load_valid = 1'b1; load_data = 32'h22222222; load_last = 1'b0;
        tick();
        check("s2_lw_b", 32'(loaded_words), 32'd2);
        load_valid = 1'b0; load_data = 32'hFFFFFFFF; load_last = 1'b1;
        tick();
        check("s2_lw_idle1", 32'(loaded_words), 32'd2);
        load_valid = 1'b1; load_data = 32'h33333333; load_last = 1'b1;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("s2_lw_c", 32'(loaded_words), 32'd3);
        check("s2_ready_drop", 32'(load_ready), 32'd0);
        hold_to_run("s2");

        tbl = '{};
        tbl.push_back('{32'd0, 32'h11111111});
        tbl.push_back('{32'd1, 32'h22222222});
        tbl.push_back('{32'd2, 32'h33333333});
        tbl.push_back('{32'd3, 32'h0000000D});
        run_table("s2");

        // Scenario 3: fill all 64 words without load_last, extra valid ignored, halted ignored in HOLD
        apply_reset();
        for (int i = 0; i < 64; i++) begin
            load_word($sformatf("s3w%0d", i), 32'h10000000 + 32'(i), 1'b0);
        end
        check("s3_loaded_words", 32'(loaded_words), 32'd64);
        check("s3_ready_drop", 32'(load_ready), 32'd0);
        load_data  = 32'hDEADBEEF;
        halted     = 1'b1;
        hold_to_run("s3");
        load_valid = 1'b0;
        halted     = 1'b0;
        check("s3_lw_after_extra", 32'(loaded_words), 32'd64);
        check("s3_done_ignored", 32'(done), 32'd0);

        tbl = '{};
        tbl.push_back('{32'd0,          32'h10000000});
        tbl.push_back('{32'd1,          32'h10000001});
        tbl.push_back('{32'd63,         32'h1000003F});
        tbl.push_back('{32'd64,         32'h0000000D});
        tbl.push_back('{32'hFFFFFFFF,   32'h0000000D});
        run_table("s3");

        // Scenario 4: asynchronous reset between edges after two accepted words
        apply_reset();
        load_word("s4w0", 32'hAAAA0000, 1'b0);
        load_word("s4w1", 32'hAAAA0001, 1'b0);
        load_valid = 1'b0;
        check("s4_lw_two", 32'(loaded_words), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check("s4_async_lw", 32'(loaded_words), 32'd0);
        check("s4_async_ready", 32'(load_ready), 32'd0);
        check("s4_async_core_reset", 32'(core_reset), 32'd1);
        @(posedge clock);
        #3;
        reset = 1'b1;
        tick();
        check("s4_ready_after_release", 32'(load_ready), 32'd1);
        load_word("s4r0", 32'h2003000A, 1'b1);
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("s4_reload_lw", 32'(loaded_words), 32'd1);
        hold_to_run("s4");

        tbl = '{};
        tbl.push_back('{32'd0, 32'h2003000A});
        tbl.push_back('{32'd1, 32'h0000000D});
        run_table("s4");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imem_server.md
Name: imem_server

Overview:
- Responder side of the core's instruction-fetch interface. The core drives a word address (`raddr`); this block returns the instruction word on `instr`.
- Owns the instruction store and loads it from a valid/ready stream before execution starts.
- Holds the core in reset until the program is loaded, then serves fetches and counts run cycles.
- Latches completion when the core raises `halted`. Sits between the testbench/program source and the Mips32-class core.

Parameters:
- ADDR_SIZE, 6, log2 of instruction store depth in 32-bit words (DEPTH = 2**ADDR_SIZE).
- DATA_WIDTH, 32, instruction word width.
- RESET_HOLD, 4, cycles `core_reset` stays asserted after load completes; legal range 1..15.

Ports:
- clock  in  1  single clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- load_valid  in  1  load word present.
- load_ready  out  1  block accepts load word.
- load_data  in  DATA_WIDTH  instruction word to store.
- load_last  in  1  marks final word of program; qualified by `load_valid`.
- raddr  in  32  word address from core (already pc>>2).
- instr  out  DATA_WIDTH  instruction returned to core.
- core_reset  out  1  active-high reset driven to core.
- halted  in  1  core halt indication.
- done  out  1  sticky: core halted during RUN.
- cycle_count  out  32  RUN cycles elapsed.
- loaded_words  out  ADDR_SIZE+1  number of words stored.

Behaviour:
- States: LOAD, HOLD, RUN, DONE. Reset (reset=0) forces LOAD asynchronously.
- Reset values: `load_ready`=0, `core_reset`=1, `done`=0, `cycle_count`=0, `loaded_words`=0, `instr`=32'h0000000D.
- `load_ready` is registered and equals (state==LOAD). It goes 1 on the first clock after reset release.
- LOAD:
  - Handshake fires on `load_valid & load_ready`.
  - Writes `mem[loaded_words]` <= `load_data` and increments `loaded_words`, both on the same edge.
  - `load_valid` without `load_ready` is ignored and no write occurs. `load_data` may change freely while not accepted.
- LOAD -> HOLD when the accepted word has `load_last`=1, or when it is word DEPTH-1 (store full; `load_last` not required).
  - `load_ready` drops the cycle after the final accept. No extra word is written.
- HOLD:
  - `core_reset`=1 and `load_ready`=0.
  - A down-counter loaded with RESET_HOLD-1 on entry. HOLD -> RUN when it reaches 0, so `core_reset` stays high for exactly RESET_HOLD cycles of HOLD.
  - `halted` is ignored.
- RUN:
  - `core_reset`=0.
  - `instr` is combinational, zero latency: `mem[raddr[ADDR_SIZE-1:0]]` when raddr < `loaded_words`, else 32'h0000000D (break). Unloaded and out-of-range fetches therefore halt the core.
  - `cycle_count` increments every RUN cycle and saturates at 32'hFFFFFFFF.
- RUN -> DONE when `halted`=1 is sampled.
  - The cycle in which `halted` is sampled is counted; later cycles are not.
- DONE:
  - `done`=1 and `core_reset`=1; `instr` = break.
  - `cycle_count` and `loaded_words` are frozen. Only reset leaves DONE.
- Outside RUN, `instr` = 32'h0000000D.
- Reset mid-load or mid-run: all state is discarded. `loaded_words` returns to 0 and the program must be reloaded. Memory contents are not cleared but are unreachable, because `loaded_words`=0.
- Memory has no reset and is written only in LOAD.

Decomposition:
- Shared package imem_pkg:
  - state enum imem_state_t {LOAD, HOLD, RUN, DONE};
  - BREAK_INSTR = 32'h0000000D;
  - RESET_HOLD width constant.
- One sub-module, imem_array:
  - DEPTH x DATA_WIDTH;
  - one synchronous write port;
  - one asynchronous read port;
  - no reset.
- FSM, counters and address bounds check stay in imem_server.

Test Plan:
- Load 3 words (0x20010005, 0x20020007, 0x0000000D; last on word 3) with `load_valid` held high:
  - `load_ready` 1 for 3 cycles then 0;
  - `loaded_words`=3;
  - `core_reset` high exactly 4 cycles after the final accept, then 0.
- Load with `load_valid` toggling every other cycle: writes only on handshake cycles; stored words match in order; `loaded_words`=3.
- RUN with raddr=1 -> `instr`=0x20020007 same cycle. With raddr=3 and with raddr=64 -> `instr`=0x0000000D.
- Load 64 words without `load_last`: enters HOLD after word 64; a 65th `load_valid` is not accepted; `loaded_words`=64.
- RUN 10 cycles then `halted`=1:
  - `done`=1 next cycle;
  - `cycle_count`=11 and stays 11;
  - `core_reset`=1.
- Assert reset for 1 cycle mid-load after 2 words, asynchronously between edges:
  - `loaded_words`=0, `load_ready`=0, `core_reset`=1 immediately;
  - reload of a 1-word program with `load_last` succeeds.
